// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared gesture decoder types and default timing constants
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        LONG_HELD
    } gesture_state_e;

    // Defaults assume a 50 MHz clock: 20 ms debounce, 1 s long press, 300 ms double gap
    localparam int KEY_DEBOUNCE_CYC   = 1_000_000;
    localparam int KEY_LONG_CYC       = 50_000_000;
    localparam int KEY_DOUBLE_GAP_CYC = 15_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_gesture_decoder_if.sv
// rtl/key_gesture_decoder_if.sv - raw key input and debounced level / gesture pulse outputs
interface key_gesture_decoder_if;

    logic key_in;
    logic key_state;
    logic short_press;
    logic long_press;
    logic double_press;

    modport master (
        output key_in,
        input  key_state, short_press, long_press, double_press
    );

    modport slave (
        input  key_in,
        output key_state, short_press, long_press, double_press
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchronizer plus stable-count debouncer with press/release strobes
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic press_ev,
    output logic rel_ev
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             pressed;
    logic             flip;

    assign pressed = ~sync2;
    assign flip    = (pressed != key_state) && (cnt == CNT_LAST);

    // Synchronizer resets to the released level so a held key is seen as a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((pressed == key_state) || flip) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= 1'b0;
            press_ev  <= 1'b0;
            rel_ev    <= 1'b0;
        end else begin
            press_ev <= flip & ~key_state;
            rel_ev   <= flip & key_state;
            if (flip) begin
                key_state <= ~key_state;
            end
        end
    end

endmodule

// File: rtl/key_gesture_decoder.sv
// rtl/key_gesture_decoder.sv - classifies debounced key gestures into short/long/double press pulses
module key_gesture_decoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = KEY_DEBOUNCE_CYC,
    parameter int LONG_CYC       = KEY_LONG_CYC,
    parameter int DOUBLE_GAP_CYC = KEY_DOUBLE_GAP_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_gesture_decoder_if.slave  bus
);

    localparam int TIMER_W = $clog2(max_int(LONG_CYC, DOUBLE_GAP_CYC) + 1);
    localparam logic [TIMER_W-1:0] LONG_T  = TIMER_W'(LONG_CYC);
    localparam logic [TIMER_W-1:0] GAP_T   = TIMER_W'(DOUBLE_GAP_CYC);
    localparam logic [TIMER_W-1:0] TIMER_1 = TIMER_W'(1);

    gesture_state_e     state;
    gesture_state_e     state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [TIMER_W-1:0] timer_inc;
    logic               key_state;
    logic               press_ev;
    logic               rel_ev;
    logic               short_nxt;
    logic               long_nxt;
    logic               double_nxt;
    logic               short_q;
    logic               long_q;
    logic               double_q;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (bus.key_in),
        .key_state (key_state),
        .press_ev  (press_ev),
        .rel_ev    (rel_ev)
    );

    assign bus.key_state    = key_state;
    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_press = double_q;

    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            short_q  <= short_nxt;
            long_q   <= long_nxt;
            double_q <= double_nxt;
        end
    end

    // Timer holds the number of cycles since the strobe that entered PRESS1/WAIT_GAP
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        case (state)
            IDLE: begin
                if (press_ev) begin
                    state_nxt = PRESS1;
                    timer_nxt = TIMER_1;
                end
            end
            PRESS1: begin
                if (rel_ev) begin
                    state_nxt = WAIT_GAP;
                    timer_nxt = TIMER_1;
                end else if (timer >= LONG_T) begin
                    state_nxt = LONG_HELD;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            WAIT_GAP: begin
                if (press_ev) begin
                    state_nxt = PRESS2;
                end else if (timer >= GAP_T) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            PRESS2: begin
                if (rel_ev) begin
                    state_nxt = IDLE;
                end
            end
            LONG_HELD: begin
                if (rel_ev) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A simultaneous strobe always beats the timer expiry
    always_comb begin
        short_nxt  = (state == WAIT_GAP) && !press_ev && (timer >= GAP_T);
        long_nxt   = (state == PRESS1) && !rel_ev && (timer >= LONG_T);
        double_nxt = (state == PRESS2) && rel_ev;
    end

endmodule

// File: doc/key_gesture_decoder.md
# key_gesture_decoder

Consumes the raw active-low push-button and classifies each user gesture as a single short press, a long press, or a double press, emitting one-cycle event pulses. It pairs with the existing key debouncer and single-pulse press path, and lets the top level map distinct gestures to distinct actions (e.g. toggle alarm, silence, change LED mode). Debounce is done internally, so `key_in` connects straight to the pin.

## Interface
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles (20 ms at 50 MHz) required to accept a level change.
- `LONG_CYC`, 50_000_000: hold time (1 s) after the accepted press that qualifies a long press.
- `DOUBLE_GAP_CYC`, 15_000_000: maximum release-to-second-press gap (300 ms) for a double press.

- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `key_in` input 1: raw button, asynchronous to `clk`, 0 = pressed.
- `key_state` output 1: debounced level, 1 = pressed.
- `short_press` output 1: one-cycle pulse, single short press.
- `long_press` output 1: one-cycle pulse, long press.
- `double_press` output 1: one-cycle pulse, double press.

## Operation
- Input path: 2-FF synchronizer. Both flops reset to 1 (released).
- Debounce counter:
  - Clears whenever the synchronized level equals `key_state`.
  - Otherwise increments.
  - On reaching `DEBOUNCE_CYC`, `key_state` flips and the counter clears.
  - The flip produces an internal `press_ev` (0→1) or `rel_ev` (1→0) strobe for one cycle.
- Gesture FSM with a shared timer. Timer width is `$clog2(max(LONG_CYC, DOUBLE_GAP_CYC)+1)`. The timer saturates and never wraps.
  - IDLE: timer=0. `press_ev` → PRESS1.
  - PRESS1: timer++ each cycle.
    - `rel_ev` before timer reaches `LONG_CYC` → WAIT_GAP, timer=0.
    - Timer reaches `LONG_CYC` while held → pulse `long_press`, go to LONG_HELD.
  - LONG_HELD: no events. `rel_ev` → IDLE.
  - WAIT_GAP: timer++.
    - `press_ev` while timer < `DOUBLE_GAP_CYC` → PRESS2.
    - Timer reaches `DOUBLE_GAP_CYC` → pulse `short_press`, go to IDLE.
  - PRESS2: `rel_ev` → pulse `double_press`, go to IDLE. Hold length in PRESS2 is ignored; no long press is reported.
- At most one event pulse is asserted in any cycle. Event pulses are mutually exclusive per gesture.
- Simultaneous cases:
  - `press_ev` in the same cycle WAIT_GAP's timer reaches `DOUBLE_GAP_CYC`: the press wins → PRESS2, no `short_press`.
  - `rel_ev` in the same cycle PRESS1's timer reaches `LONG_CYC`: the release wins → WAIT_GAP, no `long_press`.
- Reset mid-gesture:
  - All state returns to IDLE with no pulse.
  - If the key is held when `rst_n` deasserts, the debouncer sees a pressed level against `key_state`=0. The press is accepted after debounce and treated as a new gesture.

## Timing
- Reset values: `key_state`=0, `short_press`=0, `long_press`=0, `double_press`=0. FSM=IDLE, timer=0, debounce counter=0.
- `key_state` changes `DEBOUNCE_CYC`+2 clocks after `key_in` settles. Bounces shorter than `DEBOUNCE_CYC` produce no change.
- FSM reacts to `press_ev`/`rel_ev` in the same cycle the strobe is high. Event outputs are registered and appear the following cycle.
- `short_press`: `DOUBLE_GAP_CYC`+1 clocks after the release `rel_ev`.
- `long_press`: `LONG_CYC`+1 clocks after the press `press_ev`, while still held.
- `double_press`: 1 clock after the second `rel_ev`.
- Pulse width is exactly 1 clock. There is no back-pressure; consumers must sample every cycle.

## Structure
- Shared package `key_pkg`:
  - FSM state enum: IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD.
  - Default constants `KEY_DEBOUNCE_CYC`, `KEY_LONG_CYC`, `KEY_DOUBLE_GAP_CYC`, for reuse by the top level and the debouncer.
- One sub-module `key_debounce`:
  - Contains the synchronizer and debounce counter.
  - Outputs `key_state`, `press_ev`, `rel_ev`.
- FSM and timer live in `key_gesture_decoder`.

## Test plan
All directed scenarios use `DEBOUNCE_CYC`=4, `LONG_CYC`=40, `DOUBLE_GAP_CYC`=20.
- Bounce rejection: toggle `key_in` every 2 cycles for 30 cycles, then hold 1 → `key_state` stays 0 and no pulses.
- Short press: press for 10 cycles, then release → exactly one `short_press`, 21 clocks after `rel_ev`. `long_press` and `double_press` stay 0.
- Long press: hold for 60 cycles → one `long_press` 41 clocks after `press_ev`. Release gives no further pulse, and the FSM returns to IDLE.
- Double press: press 8, release 10, press 8, release → one `double_press` 1 clock after the second `rel_ev`, and no `short_press`.
- Boundary cases:
  - Second `press_ev` exactly at WAIT_GAP timer=20 → `double_press` and no `short_press`.
  - `rel_ev` exactly at PRESS1 timer=40 → `short_press` and no `long_press`.
- Reset mid-gesture: assert `rst_n`=0 during PRESS1, keep the key held, then deassert → no pulse during reset. `key_state` rises 6 clocks later, and the gesture then resolves normally.
